// File: rtl/probe_release_responder.sv
// Probe endpoint: queues incoming probes, performs one metadata lookup per probe
// with the local client, then returns a release packet to the probe's originator.
module probe_release_responder #(
   parameter logic [1:0]  MY_ID       = 2'h0,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        io_in_ready,
   input  logic        io_in_valid,
   input  logic [1:0]  io_in_bits_header_src,
   input  logic [1:0]  io_in_bits_header_dst,
   input  logic [25:0] io_in_bits_payload_addr_block,
   input  logic [1:0]  io_in_bits_payload_p_type,
   output logic        io_client_req_valid,
   input  logic        io_client_req_ready,
   output logic [25:0] io_client_req_addr_block,
   output logic [1:0]  io_client_req_p_type,
   input  logic        io_client_resp_valid,
   input  logic        io_client_resp_dirty,
   input  logic        io_out_ready,
   output logic        io_out_valid,
   output logic [1:0]  io_out_bits_header_src,
   output logic [1:0]  io_out_bits_header_dst,
   output logic [25:0] io_out_bits_payload_addr_block,
   output logic [2:0]  io_out_bits_payload_r_type,
   output logic        io_err
);

   localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_SEND = 2'd3
   } state_t;

   // Reserved probe type 3 is answered as a copy.
   function automatic logic [2:0] release_type(input logic [1:0] p_type, input logic dirty);
      logic [2:0] kind;
      case (p_type)
         2'd0:    kind = 3'd0;
         2'd1:    kind = 3'd1;
         default: kind = 3'd2;
      endcase
      return dirty ? kind : kind + 3'd3;
   endfunction

   logic [31:0]   mem_q [QUEUE_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   state_t        state_q, state_d;
   logic [25:0]   addr_q, addr_d;
   logic [1:0]    ptype_q, ptype_d;
   logic [1:0]    dst_q, dst_d;
   logic [2:0]    rtype_q, rtype_d;
   logic          err_q, err_d;

   logic          push_s, pop_s, full_s, empty_s;
   logic [31:0]   head_s;
   logic [1:0]    head_src_s, head_dst_s, head_ptype_s;
   logic [25:0]   head_addr_s;

   assign full_s       = (count_q == DEPTH_C);
   assign empty_s      = (count_q == {CW{1'b0}});
   assign push_s       = io_in_valid & ~full_s;
   assign head_s       = mem_q[rd_ptr_q];
   assign head_src_s   = head_s[31:30];
   assign head_dst_s   = head_s[29:28];
   assign head_addr_s  = head_s[27:2];
   assign head_ptype_s = head_s[1:0];

   // Service sequencer: pop/check the head, request lookup, await result, emit release.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ptype_d = ptype_q;
      dst_d   = dst_q;
      rtype_d = rtype_q;
      err_d   = err_q;
      pop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s = 1'b1;
               if (head_dst_s == MY_ID) begin
                  addr_d  = head_addr_s;
                  ptype_d = head_ptype_s;
                  dst_d   = head_src_s;
                  state_d = S_REQ;
                  if (head_ptype_s == 2'd3) begin
                     err_d = 1'b1;
                  end else begin
                     err_d = err_q;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (io_client_req_ready) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (io_client_resp_valid) begin
               rtype_d = release_type(ptype_q, io_client_resp_dirty);
               state_d = S_SEND;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_SEND: begin
            if (io_out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_SEND;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO pointer and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = push_s ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Probe storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {io_in_bits_header_src, io_in_bits_header_dst,
                             io_in_bits_payload_addr_block, io_in_bits_payload_p_type};
      end
   end

   // State and captured-field registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         state_q  <= S_IDLE;
         addr_q   <= 26'h0;
         ptype_q  <= 2'h0;
         dst_q    <= 2'h0;
         rtype_q  <= 3'h0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         addr_q   <= addr_d;
         ptype_q  <= ptype_d;
         dst_q    <= dst_d;
         rtype_q  <= rtype_d;
         err_q    <= err_d;
      end
   end

   assign io_in_ready                    = ~full_s;
   assign io_client_req_valid            = (state_q == S_REQ);
   assign io_client_req_addr_block       = addr_q;
   assign io_client_req_p_type           = ptype_q;
   assign io_out_valid                   = (state_q == S_SEND);
   assign io_out_bits_header_src         = MY_ID;
   assign io_out_bits_header_dst         = dst_q;
   assign io_out_bits_payload_addr_block = addr_q;
   assign io_out_bits_payload_r_type     = rtype_q;
   assign io_err                         = err_q;

endmodule

// File: tb/tb_probe_release_responder.sv
// Scoreboard bench for probe_release_responder: randomized and directed probes,
// a client responder model, and a release monitor checking against queued expectations.
module tb_probe_release_responder;

   localparam logic [1:0] MY_ID = 2'h1;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_in_ready, io_in_valid;
   logic [1:0]  io_in_bits_header_src, io_in_bits_header_dst, io_in_bits_payload_p_type;
   logic [25:0] io_in_bits_payload_addr_block;
   logic        io_client_req_valid, io_client_req_ready;
   logic [25:0] io_client_req_addr_block;
   logic [1:0]  io_client_req_p_type;
   logic        io_client_resp_valid, io_client_resp_dirty;
   logic        io_out_ready, io_out_valid;
   logic [1:0]  io_out_bits_header_src, io_out_bits_header_dst;
   logic [25:0] io_out_bits_payload_addr_block;
   logic [2:0]  io_out_bits_payload_r_type;
   logic        io_err;

   probe_release_responder #(.MY_ID(MY_ID), .QUEUE_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
      .io_in_bits_header_src(io_in_bits_header_src), .io_in_bits_header_dst(io_in_bits_header_dst),
      .io_in_bits_payload_addr_block(io_in_bits_payload_addr_block),
      .io_in_bits_payload_p_type(io_in_bits_payload_p_type),
      .io_client_req_valid(io_client_req_valid), .io_client_req_ready(io_client_req_ready),
      .io_client_req_addr_block(io_client_req_addr_block), .io_client_req_p_type(io_client_req_p_type),
      .io_client_resp_valid(io_client_resp_valid), .io_client_resp_dirty(io_client_resp_dirty),
      .io_out_ready(io_out_ready), .io_out_valid(io_out_valid),
      .io_out_bits_header_src(io_out_bits_header_src), .io_out_bits_header_dst(io_out_bits_header_dst),
      .io_out_bits_payload_addr_block(io_out_bits_payload_addr_block),
      .io_out_bits_payload_r_type(io_out_bits_payload_r_type),
      .io_err(io_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [1:0] dst; logic [25:0] addr; logic [2:0] rtype; logic err; } rel_t;
   typedef struct { logic [25:0] addr; logic [1:0] pt; } req_t;

   rel_t exp_rel[$];
   req_t exp_req[$];
   logic exp_dirty[$];
   logic err_model;
   int   checks = 0;
   int   errors = 0;
   int   req_mode = 1;     // 0 low, 1 high, 2 random
   int   out_mode = 1;
   int   resp_delay = 0;   // negative: random 0..3
   int   stray_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] rtype_ref(input logic [1:0] pt, input logic dirty);
      int k;
      k = (pt == 2'd3) ? 2 : int'(pt);
      return 3'(dirty ? k : k + 3);
   endfunction

   task automatic model_accept(input logic [1:0] src, input logic [1:0] dst,
                               input logic [25:0] addr, input logic [1:0] pt, input logic d);
      rel_t r;
      req_t q;
      if (dst == MY_ID) begin
         q.addr = addr;
         q.pt   = pt;
         exp_req.push_back(q);
         exp_dirty.push_back(d);
         if (pt == 2'd3) err_model = 1'b1;
         r.dst   = src;
         r.addr  = addr;
         r.rtype = rtype_ref(pt, d);
         r.err   = err_model;
         exp_rel.push_back(r);
      end else begin
         err_model = 1'b1;
      end
   endtask

   // Called just after a posedge; returns just after the posedge that accepted the probe.
   task automatic send_probe(input logic [1:0] src, input logic [1:0] dst,
                             input logic [25:0] addr, input logic [1:0] pt, input int dirty);
      logic d;
      bit   done;
      d = (dirty < 0) ? 1'($urandom % 2) : 1'(dirty);
      io_in_valid = 1'b1;
      io_in_bits_header_src = src;
      io_in_bits_header_dst = dst;
      io_in_bits_payload_addr_block = addr;
      io_in_bits_payload_p_type = pt;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (io_in_ready) begin
            model_accept(src, dst, addr, pt, d);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      io_in_valid = 1'b0;
      if (!done) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      int i;
      for (i = 0; i < 2000 && exp_rel.size() != 0; i++) @(negedge clk);
      check("drain_pending", 32'(exp_rel.size()), 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_rel.delete();
      exp_req.delete();
      exp_dirty.delete();
      err_model = 1'b0;
   endtask

   // Ready drivers for the client request and network output channels.
   initial begin
      forever begin
         io_client_req_ready = (req_mode == 2) ? 1'($urandom % 2) : (req_mode == 1);
         io_out_ready        = (out_mode == 2) ? 1'($urandom % 2) : (out_mode == 1);
         @(posedge clk);
         #2;
      end
   end

   // Client model: answers each accepted lookup with the dirty bit chosen at probe issue.
   initial begin
      req_t r;
      logic d;
      int   dly;
      int   stray_done;
      stray_done = 0;
      io_client_resp_valid = 1'b0;
      io_client_resp_dirty = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && io_client_req_valid && io_client_req_ready) begin
            d = 1'b0;
            if (exp_req.size() == 0) begin
               check("unexpected_request", 32'd1, 32'd0);
            end else begin
               r = exp_req.pop_front();
               d = exp_dirty.pop_front();
               check("req_addr", 32'(io_client_req_addr_block), 32'(r.addr));
               check("req_ptype", 32'(io_client_req_p_type), 32'(r.pt));
            end
            dly = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
            @(posedge clk);
            repeat (dly) @(posedge clk);
            #1;
            io_client_resp_valid = 1'b1;
            io_client_resp_dirty = d;
            @(posedge clk);
            #1;
            io_client_resp_valid = 1'b0;
         end else if (stray_cnt != stray_done) begin
            stray_done++;
            @(posedge clk);
            #1;
            io_client_resp_valid = 1'b1;
            io_client_resp_dirty = 1'($urandom % 2);
            @(posedge clk);
            #1;
            io_client_resp_valid = 1'b0;
         end
      end
   end

   // Release monitor: stability while stalled, scoreboard compare on handshake.
   initial begin
      rel_t e;
      bit   pending;
      logic [32:0] prev;
      pending = 1'b0;
      prev = 33'h0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pending = 1'b0;
         end else if (io_out_valid) begin
            if (pending)
               check("out_stable", 32'({io_out_bits_header_src, io_out_bits_header_dst,
                     io_out_bits_payload_addr_block, io_out_bits_payload_r_type} != prev), 32'd0);
            if (io_out_ready) begin
               pending = 1'b0;
               if (exp_rel.size() == 0) begin
                  check("unexpected_release", 32'd1, 32'd0);
               end else begin
                  e = exp_rel.pop_front();
                  check("rel_src", 32'(io_out_bits_header_src), 32'(MY_ID));
                  check("rel_dst", 32'(io_out_bits_header_dst), 32'(e.dst));
                  check("rel_addr", 32'(io_out_bits_payload_addr_block), 32'(e.addr));
                  check("rel_rtype", 32'(io_out_bits_payload_r_type), 32'(e.rtype));
                  check("rel_err", 32'(io_err), 32'(e.err));
               end
            end else begin
               pending = 1'b1;
               prev = {io_out_bits_header_src, io_out_bits_header_dst,
                       io_out_bits_payload_addr_block, io_out_bits_payload_r_type};
            end
         end else begin
            if (pending) check("out_valid_dropped", 32'd0, 32'd1);
            pending = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_req;
      int i;
      err_model = 1'b0;
      reset = 1'b1;
      io_in_valid = 1'b0;
      io_in_bits_header_src = 2'h0;
      io_in_bits_header_dst = 2'h0;
      io_in_bits_payload_addr_block = 26'h0;
      io_in_bits_payload_p_type = 2'h0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", 32'(io_in_ready), 32'd1);
      check("rst_req_valid", 32'(io_client_req_valid), 32'd0);
      check("rst_out_valid", 32'(io_out_valid), 32'd0);
      check("rst_err", 32'(io_err), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Minimum-latency single probe.
      send_probe(2'd2, 2'd1, 26'h0ABCDE, 2'd0, 1);
      @(negedge clk);
      check("lat_c1_req", 32'(io_client_req_valid), 32'd0);
      @(negedge clk);
      check("lat_c2_req", 32'(io_client_req_valid), 32'd1);
      @(negedge clk);
      check("lat_c3_out", 32'(io_out_valid), 32'd0);
      @(negedge clk);
      check("lat_c4_out", 32'(io_out_valid), 32'd1);
      wait_drain();

      // Back-pressure from the client fills the FIFO.
      req_mode = 0;
      send_probe(2'd0, 2'd1, 26'h0000111, 2'd1, -1);
      send_probe(2'd2, 2'd1, 26'h0000222, 2'd2, -1);
      send_probe(2'd3, 2'd1, 26'h0000333, 2'd0, -1);
      for (i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_in_ready", 32'(io_in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      req_mode = 1;
      send_probe(2'd0, 2'd1, 26'h0000444, 2'd2, -1);
      wait_drain();

      // Release type mapping, including the reserved type.
      send_probe(2'd2, 2'd1, 26'h1234567, 2'd1, 0);
      wait_drain();
      check("err_before_rsvd", 32'(io_err), 32'd0);
      send_probe(2'd3, 2'd1, 26'h2345678, 2'd3, 0);
      wait_drain();
      check("err_after_rsvd", 32'(io_err), 32'd1);
      pulse_reset();

      // Misaddressed probe is dropped and flags an error.
      send_probe(2'd2, 2'd3, 26'h0055555, 2'd0, -1);
      @(negedge clk);
      check("drop_err_pop", 32'(io_err), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("drop_err_set", 32'(io_err), 32'd1);
      check("drop_no_req", 32'(io_client_req_valid), 32'd0);
      @(posedge clk);
      #1;
      send_probe(2'd0, 2'd1, 26'h0066666, 2'd2, -1);
      wait_drain();
      pulse_reset();

      // Stalled release with a stray lookup response.
      out_mode = 0;
      send_probe(2'd0, 2'd1, 26'h3FFFFFF, 2'd2, 1);
      for (i = 0; i < 50 && !io_out_valid; i++) @(negedge clk);
      check("stall_out_valid", 32'(io_out_valid), 32'd1);
      stray_cnt++;
      for (i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("stall_hold", 32'(io_out_valid), 32'd1);
      end
      out_mode = 1;
      wait_drain();

      // Reset while waiting for a lookup with a second probe queued.
      resp_delay = 12;
      send_probe(2'd2, 2'd1, 26'h0077777, 2'd0, -1);
      send_probe(2'd3, 2'd1, 26'h0088888, 2'd1, -1);
      @(posedge clk);
      #1;
      pulse_reset();
      @(negedge clk);
      check("rstw_req_valid", 32'(io_client_req_valid), 32'd0);
      check("rstw_out_valid", 32'(io_out_valid), 32'd0);
      check("rstw_in_ready", 32'(io_in_ready), 32'd1);
      check("rstw_err", 32'(io_err), 32'd0);
      seen_req = 1'b0;
      for (i = 0; i < 25; i++) begin
         @(negedge clk);
         if (io_client_req_valid) seen_req = 1'b1;
      end
      check("rstw_no_req", 32'(seen_req), 32'd0);
      @(posedge clk);
      #1;
      resp_delay = -1;

      // Randomized traffic.
      req_mode = 2;
      out_mode = 2;
      for (i = 0; i < 40; i++) begin
         send_probe(2'($urandom), ($urandom % 8 == 0) ? 2'd3 : MY_ID,
                    26'($urandom), 2'($urandom), -1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      wait_drain();
      req_mode = 1;
      out_mode = 1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
